rtc_xpram: RTL and testbench

RTC_XPRAM -- requirements
Module: rtc_xpram

---
 rtl/rtc_pkg.sv | 40 ++++
 rtl/rtc_serial.sv | 53 +++++
 rtl/rtc_xpram.sv | 167 ++++++++++++++++
 tb/tb_rtc_xpram.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC/XPRAM block: command decode fields,
// serial FSM states, epoch offset and the classic 20-byte PRAM power-on image.
package rtc_pkg;

  localparam logic [31:0] EPOCH_OFFSET_DEF = 32'd2082844800;

  // Command byte fields: z aaaaa tt
  localparam logic [1:0] CMD_TAIL = 2'b01;
  localparam logic [3:0] OP_EXT   = 4'b0111;   // cmd[6:3]
  localparam logic [4:0] OP_TEST  = 5'b01100;  // cmd[6:2]
  localparam logic [4:0] OP_WP    = 5'b01101;  // cmd[6:2]

  typedef enum logic [2:0] {
    CMD   = 3'd0,
`ifdef RTC_XPRAM_EN
    XADDR = 3'd1,
`endif
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } ser_state_e;

  typedef enum logic [1:0] {T_SECS, T_TEST, T_WP, T_PRAM} tgt_e;

  localparam logic [0:19][7:0] PRAM_DEF = {
    8'hA8, 8'h00, 8'h00, 8'h22, 8'hCC, 8'h0A, 8'hCC, 8'h0A, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h02, 8'h63, 8'h00, 8'h03, 8'h88, 8'h00, 8'h6C
  };

  typedef logic [255:0][7:0] pram_img_t;

  function automatic pram_img_t pram_default();
    pram_img_t img = '0;
    for (int i = 0; i < 20; i++) img[i] = PRAM_DEF[i];
    return img;
  endfunction

  localparam pram_img_t PRAM_IMG = pram_default();

endpackage

// File: rtl/rtc_serial.sv
// Serial front end: single-register ck edge detect, bit counter, input shifter
// and the read-data output register.
module rtc_serial (
  input  logic       clk,
  input  logic       _reset,
  input  logic       _cs,
  input  logic       ck,
  input  logic       dat_i,
  input  logic       shift_out,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       byte_done,
  output logic       ck_fall,
  output logic [7:0] rx_byte,
  output logic       dat_o
);

  logic       ck_d;
  logic       rise;
  logic [2:0] bit_cnt;
  logic [6:0] sh;
  logic [7:0] dout;

  assign rise      = ~ck_d & ck & ~_cs;
  assign ck_fall   = ck_d & ~ck & ~_cs;
  assign byte_done = rise & (bit_cnt == 3'd7);
  // Completed byte includes the bit being sampled on this rise.
  assign rx_byte   = {sh, dat_i};

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ck_d    <= 1'b1;
      bit_cnt <= 3'd0;
      sh      <= 7'd0;
      dout    <= 8'd0;
      dat_o   <= 1'b1;
    end else begin
      ck_d <= ck;
      if (_cs) begin
        bit_cnt <= 3'd0;
        dat_o   <= 1'b1;
      end else begin
        if (rise) begin
          sh      <= {sh[5:0], dat_i};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (shift_out) dat_o <= dout[3'd7 - bit_cnt];
      end
      if (load) dout <= load_byte;
    end
  end

endmodule

// File: rtl/rtc_xpram.sv
// Mac-style RTC: 1 Hz seconds counter, test/write-protect registers and PRAM over
// a 3-wire serial port. Define RTC_XPRAM_EN for 256-byte extended PRAM access.
module rtc_xpram
  import rtc_pkg::*;
#(
  parameter int          CLK_HZ       = 32_000_000,
  parameter int          PRAM_DEPTH   = 256,
  parameter logic [31:0] EPOCH_OFFSET = EPOCH_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic [32:0] timestamp,
  input  logic        ts_valid,
  input  logic        _cs,
  input  logic        ck,
  input  logic        dat_i,
  output logic        dat_o,
  output logic        tick_1hz
);

`ifdef RTC_XPRAM_EN
  localparam int DEPTH = PRAM_DEPTH;
`else
  localparam int DEPTH = (PRAM_DEPTH < 20) ? PRAM_DEPTH : 20;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  ser_state_e state, nstate;
  tgt_e       kind, nkind;
  logic [7:0] addr, naddr;
  logic       rd_z, nz;
  logic       load, wr;
  logic [7:0] rd_val;
  logic       byte_done, ck_fall;
  logic [7:0] rx;

  logic [31:0]       secs;
  logic [3:0][7:0]   secs_b, secs_new;
  logic [PW-1:0]     presc;
  logic              wrap;
  logic [7:0]        wp, test;
  logic [DEPTH-1:0][7:0] pram = PRAM_IMG[DEPTH-1:0];
  logic              ts_unused;

  assign ts_unused = timestamp[32];
  assign secs_b    = secs;
  assign wrap      = (presc == PW'(CLK_HZ - 1));

  rtc_serial u_serial (
    .clk       (clk),
    ._reset    (_reset),
    ._cs       (_cs),
    .ck        (ck),
    .dat_i     (dat_i),
    .shift_out (ck_fall && state == RDATA),
    .load      (load),
    .load_byte (rd_val),
    .byte_done (byte_done),
    .ck_fall   (ck_fall),
    .rx_byte   (rx),
    .dat_o     (dat_o)
  );

  always_comb begin
    nstate = state;
    nkind  = kind;
    naddr  = addr;
    nz     = rd_z;
    wr     = 1'b0;
    case (state)
      CMD: if (byte_done) begin
        nz    = rx[7];
        naddr = {6'd0, rx[3:2]};
        if (rx[6:3] == OP_EXT) begin
`ifdef RTC_XPRAM_EN
          naddr  = {rx[2:0], 5'd0};
          nstate = XADDR;
`else
          nstate = DONE;
`endif
        end else if (rx[1:0] != CMD_TAIL) begin
          nstate = DONE;
        end else begin
          if (rx[6]) begin
            nkind = T_PRAM;
            naddr = {4'd0, rx[5:2]};
          end else if (!rx[5]) begin
            nkind = T_SECS;
          end else if (!rx[4]) begin
            nkind = T_PRAM;
            naddr = {6'b000100, rx[3:2]};
          end else if (rx[6:2] == OP_TEST) begin
            nkind = T_TEST;
          end else begin
            nkind = T_WP;
          end
          nstate = rx[7] ? RDATA : WDATA;
        end
      end
`ifdef RTC_XPRAM_EN
      XADDR: if (byte_done) begin
        nkind  = T_PRAM;
        naddr  = {addr[7:5], rx[6:2]};
        nstate = rd_z ? RDATA : WDATA;
      end
`endif
      WDATA: if (byte_done) begin
        wr     = 1'b1;
        nstate = DONE;
      end
      RDATA: if (byte_done) nstate = DONE;
      DONE:  nstate = DONE;
      default: nstate = CMD;
    endcase
    if (_cs) nstate = CMD;
    // The read byte is captured as the last command/address bit lands.
    load = byte_done && (nstate == RDATA);
  end

  always_comb begin
    rd_val = 8'h00;
    case (nkind)
      T_SECS: rd_val = secs_b[naddr[1:0]];
      T_TEST: rd_val = test;
      T_WP:   rd_val = wp;
      T_PRAM: if (32'(naddr) < DEPTH) rd_val = pram[naddr[AW-1:0]];
    endcase
  end

  always_comb begin
    secs_new = secs_b;
    secs_new[addr[1:0]] = rx;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state    <= CMD;
      kind     <= T_SECS;
      addr     <= 8'd0;
      rd_z     <= 1'b0;
      presc    <= '0;
      secs     <= 32'd0;
      tick_1hz <= 1'b0;
      wp       <= 8'h00;
      test     <= 8'h00;
    end else begin
      state    <= nstate;
      kind     <= nkind;
      addr     <= naddr;
      rd_z     <= nz;
      tick_1hz <= wrap;
      presc    <= (ts_valid || wrap) ? '0 : presc + 1'b1;
      if (wr && kind == T_WP) wp <= rx;
      if (wr && !wp[7] && kind == T_TEST) test <= rx;
      // Host time load beats a serial write, which beats the 1 Hz increment.
      if (ts_valid)                            secs <= timestamp[31:0] + EPOCH_OFFSET;
      else if (wr && !wp[7] && kind == T_SECS) secs <= secs_new;
      else if (wrap && !test[7])               secs <= secs + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !wp[7] && kind == T_PRAM && 32'(addr) < DEPTH) pram[addr[AW-1:0]] <= rx;
  end

endmodule

// File: tb/tb_rtc_xpram.sv
// Directed bench for rtc_xpram: seconds/tick timing, secs/test/WP/PRAM access,
// write protect, aborted transfers and reset during a read.
module tb_rtc_xpram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [32:0] timestamp;
  logic        ts_valid;
  logic        cs_n;
  logic        ck;
  logic        dat_i;
  logic        dat_o;
  logic        tick_1hz;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] EPOCH = 32'd2082844800;  // 0x7C25B080

  rtc_xpram #(.CLK_HZ(16)) dut (
    .clk       (clk),
    ._reset    (rst_n),
    .timestamp (timestamp),
    .ts_valid  (ts_valid),
    ._cs       (cs_n),
    .ck        (ck),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .tick_1hz  (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      ck = 1'b0; dat_i = tx[i];
      repeat (3) @(negedge clk);
      rx[i] = dat_o;
      ck = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic wr(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    cs_n = 1'b0; repeat (2) @(negedge clk);
    xbyte(c, r); xbyte(d, r);
    cs_n = 1'b1; repeat (3) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] c, output logic [7:0] d);
    logic [7:0] r;
    cs_n = 1'b0; repeat (2) @(negedge clk);
    xbyte(c, r); xbyte(8'h00, d);
    cs_n = 1'b1; repeat (3) @(negedge clk);
  endtask

  task automatic xwr(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    cs_n = 1'b0; repeat (2) @(negedge clk);
    xbyte(c, r); xbyte(a, r); xbyte(d, r);
    cs_n = 1'b1; repeat (3) @(negedge clk);
  endtask

  task automatic xrd(input logic [7:0] c, input logic [7:0] a, output logic [7:0] d);
    logic [7:0] r;
    cs_n = 1'b0; repeat (2) @(negedge clk);
    xbyte(c, r); xbyte(a, r); xbyte(8'h00, d);
    cs_n = 1'b1; repeat (3) @(negedge clk);
  endtask

  task automatic ts_load(input logic [32:0] ts);
    timestamp = ts; ts_valid = 1'b1;
    @(negedge clk);
    ts_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int ticks;
    rst_n = 1'b0; cs_n = 1'b1; ck = 1'b1; dat_i = 1'b0;
    ts_valid = 1'b0; timestamp = '0;
    repeat (3) @(negedge clk);
    chk("rst_dat_o", 32'(dat_o), 32'd1);
    chk("rst_tick", 32'(tick_1hz), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Seconds tick: 48 clocks at CLK_HZ=16 after a load
    ts_load(33'd0);
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (tick_1hz) ticks++;
    end
    chk("tick_count", 32'(ticks), 32'd3);
    chk("secs_plus3", dut.secs, EPOCH + 32'd3);

    // Freeze secs via test[7], then read each byte of the epoch value
    wr(8'h31, 8'h80);
    rd(8'hB1, d); chk("test_rd", 32'(d), 32'h80);
    ts_load(33'd0);
    repeat (40) @(negedge clk);
    rd(8'h81, d); chk("secs_b0", 32'(d), 32'h80);
    rd(8'h85, d); chk("secs_b1", 32'(d), 32'hB0);
    rd(8'h89, d); chk("secs_b2", 32'(d), 32'h25);
    rd(8'h8D, d); chk("secs_b3", 32'(d), 32'h7C);
    ts_load(33'h1_0000_0010);
    rd(8'h81, d); chk("ts_bit32", 32'(d), 32'h90);
    wr(8'h09, 8'h11);
    rd(8'h89, d); chk("secs_wr_b2", 32'(d), 32'h11);
    rd(8'h99, d); chk("secs_bit4_dc", 32'(d), 32'h11);

    // Reset in the middle of a read of secs byte 3 (0x7C, MSB 0)
    cs_n = 1'b0; repeat (2) @(negedge clk);
    xbyte(8'h8D, d);
    ck = 1'b0; repeat (3) @(negedge clk);
    chk("rdata_bit7", 32'(dat_o), 32'd0);
    rst_n = 1'b0; #1;
    chk("rst_async_dat_o", 32'(dat_o), 32'd1);
    chk("rst_secs", dut.secs, 32'd0);
    cs_n = 1'b1; ck = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(8'hC1, d); chk("pram0_kept", 32'(d), 32'hA8);
    rd(8'h8D, d); chk("secs_b3_after_rst", 32'(d), 32'h00);
    rd(8'hB1, d); chk("test_after_rst", 32'(d), 32'h00);

    // Write protect
    wr(8'h35, 8'h80);
    rd(8'hB5, d); chk("wp_rd", 32'(d), 32'h80);
    wr(8'h41, 8'h5A);
    rd(8'hC1, d); chk("wp_blocks", 32'(d), 32'hA8);
    wr(8'h35, 8'h00);
    wr(8'h41, 8'h5A);
    rd(8'hC1, d); chk("wp_cleared", 32'(d), 32'h5A);

    // Abort after 4 data bits: no write, next command decodes cleanly
    cs_n = 1'b0; repeat (2) @(negedge clk);
    xbyte(8'h45, d);
    for (int i = 0; i < 4; i++) begin
      ck = 1'b0; dat_i = 1'b1; repeat (3) @(negedge clk);
      ck = 1'b1; repeat (3) @(negedge clk);
    end
    cs_n = 1'b1; repeat (3) @(negedge clk);
    rd(8'hC5, d); chk("abort_nowr", 32'(d), 32'h00);

    // PRAM 0x10..0x13 window
    rd(8'hA1, d); chk("pram10_def", 32'(d), 32'h03);
    wr(8'h25, 8'h3C);
    rd(8'hA5, d); chk("pram11_wr", 32'(d), 32'h3C);

    // Extended access to address 0xFF and 0x11
    xwr(8'h3F, 8'h7C, 8'hA5);
    xrd(8'hBF, 8'h7C, d);
`ifdef RTC_XPRAM_EN
    chk("xpram_ff", 32'(d), 32'hA5);
    xrd(8'hB8, 8'h44, d); chk("xpram_11", 32'(d), 32'h3C);
`else
    chk("xpram_off", 32'(d), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
